// File: rtl/serial_pkg.sv
// Shared types and constants for the serial pattern transmitter.
//   state_t : transmitter FSM states (PAR used only with parity enabled)
//   X_IDLE  : level driven on the serial line when nothing is being sent
//   lw_of   : width of a length field able to hold 0..width
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    PAR  = 2'd2
  } state_t;

  localparam logic X_IDLE = 1'b0;

  function automatic int unsigned lw_of(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Start/ready/done handshake plus serial line of the pattern transmitter.
//   start, din, nbits : request from the controller
//   x                 : serial data out
//   ready, busy, done : transmitter status
interface serial_pattern_tx_if
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned LW = lw_of(WIDTH);

  logic             start;
  logic [WIDTH-1:0] din;
  logic [LW-1:0]    nbits;
  logic             x;
  logic             ready;
  logic             busy;
  logic             done;

  modport master (
    output start, din, nbits,
    input  x, ready, busy, done
  );

  modport slave (
    input  start, din, nbits,
    output x, ready, busy, done
  );
endinterface

// File: rtl/serial_pattern_tx_piso_shift.sv
// WIDTH-bit parallel-in/serial-out register, MSB first.
//   clk, rst   : clock, async active-high reset (clears register)
//   i_load     : load i_din (takes priority over shift)
//   i_shift    : shift left by one, filling with the idle line level
//   i_din      : parallel load value
//   o_msb      : current MSB, registered
module piso_shift
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_din;
    end else if (i_shift) begin
      r_sr <= {r_sr[WIDTH-2:0], X_IDLE};
    end
  end

  assign o_msb = r_sr[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: loads up to WIDTH bits and sends them MSB-first,
// one bit per clock, with a start/ready/done handshake.
//   clk, rst : clock, async active-high reset
//   bus      : serial_pattern_tx_if.slave (start/din/nbits in; x/ready/busy/done out)
// Optional: define SERIAL_PATTERN_TX_PARITY_EN to append an even-parity bit.
module serial_pattern_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_pattern_tx_if.slave bus
);

  localparam int unsigned   LW    = lw_of(WIDTH);
  localparam logic [LW-1:0] N_MAX = LW'(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LW-1:0]    r_cnt;
  logic [LW-1:0]    w_cnt_nxt;
  logic [LW-1:0]    w_nbits;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_load;
  logic             w_shift;
  logic             w_msb;
  logic [WIDTH-1:0] w_aligned;
  logic [WIDTH-1:0] w_load_val;

  // Clamp the requested length, then left-align so din[n-1] lands on the MSB.
  assign w_nbits   = (bus.nbits > N_MAX) ? N_MAX : bus.nbits;
  assign w_aligned = bus.din << (N_MAX - w_nbits);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  logic r_par;

  // Bits outside the aligned window are zero, so this is the XOR of the sent bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (r_state == IDLE && w_load) begin
      r_par <= ^w_aligned;
    end
  end
`endif

  // State, counter and registered status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_state_nxt == IDLE);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
    end
  end

  // Next state; done is computed one cycle early so it lines up with the last bit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_load_val  = w_aligned;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (w_nbits == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_cnt_nxt   = w_nbits;
            w_state_nxt = SEND;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            w_done_nxt  = 1'b0;
`else
            w_done_nxt  = (w_nbits == LW'(1));
`endif
          end
        end
      end
      SEND: begin
        w_cnt_nxt = r_cnt - LW'(1);
        if (r_cnt == LW'(1)) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          // Overwrite the drained register with the parity bit for one cycle.
          w_state_nxt = PAR;
          w_load      = 1'b1;
          w_load_val  = {r_par, {(WIDTH-1){X_IDLE}}};
          w_done_nxt  = 1'b1;
`else
          w_state_nxt = IDLE;
          w_shift     = 1'b1;
`endif
        end else begin
          w_shift = 1'b1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          w_done_nxt = 1'b0;
`else
          w_done_nxt = (r_cnt == LW'(2));
`endif
        end
      end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      PAR: begin
        w_state_nxt = IDLE;
        w_shift     = 1'b1;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  piso_shift #(.WIDTH(WIDTH)) u_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_din   (w_load_val),
    .o_msb   (w_msb)
  );

  assign bus.x     = w_msb;
  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: scoreboard of per-cycle expected line/status.
module tb_serial_pattern_tx;
  import serial_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LW    = lw_of(WIDTH);
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic x;
    logic busy;
    logic done;
    logic ready;
  } obs_t;

  localparam obs_t IDLE_OBS = '{x: 1'b0, busy: 1'b0, done: 1'b0, ready: 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   mon_en = 1'b0;
  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];

  serial_pattern_tx_if #(.WIDTH(WIDTH)) bus ();

  serial_pattern_tx #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.x     = bus.x;
    o.busy  = bus.busy;
    o.done  = bus.done;
    o.ready = bus.ready;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got x=%b busy=%b done=%b ready=%b, want x=%b busy=%b done=%b ready=%b",
               name, $time, act.x, act.busy, act.done, act.ready,
               exp.x, exp.busy, exp.done, exp.ready);
    end
  endtask

  // Reference model: one expected record per cycle following the accepting edge.
  function automatic int eff_len(input int n);
    return (n > int'(WIDTH)) ? int'(WIDTH) : n;
  endfunction

  task automatic push_expected(input logic [WIDTH-1:0] d, input int n_req);
    int   n;
    logic par;
    obs_t o;
    n   = eff_len(n_req);
    par = 1'b0;
    if (n == 0) begin
      o = '{x: 1'b0, busy: 1'b0, done: 1'b1, ready: 1'b1};
      exp_q.push_back(o);
    end else begin
      for (int k = n - 1; k >= 0; k--) begin
        par = par ^ d[k];
        o = '{x: d[k], busy: 1'b1, done: (k == 0) && !PAR_EN, ready: 1'b0};
        exp_q.push_back(o);
      end
      if (PAR_EN) begin
        o = '{x: par, busy: 1'b1, done: 1'b1, ready: 1'b0};
        exp_q.push_back(o);
      end
    end
  endtask

  // Monitor: every cycle, compare against the scoreboard or the idle state.
  always @(negedge clk) begin
    obs_t e;
    if (mon_en && !rst) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("line", sample(), e);
      end else begin
        check("idle", sample(), IDLE_OBS);
      end
    end
  end

  // Issue one request; called #1 after a posedge while the transmitter is idle.
  // Returns #1 after the edge at which the next request could be accepted - 1.
  task automatic send(input logic [WIDTH-1:0] d, input int n, input bit junk,
                      input logic [WIDTH-1:0] junk_din);
    int len;
    bus.start = 1'b1;
    bus.din   = d;
    bus.nbits = LW'(n);
    @(posedge clk);
    #1;
    push_expected(d, n);
    bus.start = 1'b0;
    bus.din   = WIDTH'($urandom);
    bus.nbits = LW'($urandom);
    len = eff_len(n);
    if (len > 0 && PAR_EN) len++;
    for (int i = 0; i < len; i++) begin
      if (junk) begin
        bus.start = 1'b1;
        bus.din   = junk_din;
        bus.nbits = LW'($urandom);
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic idle_cycles(input int k);
    bus.start = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.din   = '0;
    bus.nbits = '0;
    #1 rst = 1'b1;
    #2;
    check("reset_state", sample(), IDLE_OBS);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // 4-bit pattern 1011
    send(8'b0000_1011, 4, 1'b0, '0);
    idle_cycles(2);
    // full width with ignored restarts
    send(8'hA5, 8, 1'b1, 8'hFF);
    idle_cycles(1);
    // zero length, then clamped length
    send(8'h3C, 0, 1'b0, '0);
    idle_cycles(2);
    send(8'h5A, 12, 1'b0, '0);
    // back-to-back 3-bit patterns with single idle gap
    send(8'b0000_0101, 3, 1'b0, '0);
    send(8'b0000_0110, 3, 1'b0, '0);
    // single bit, and zero length directly followed by a pattern
    send(8'h01, 1, 1'b0, '0);
    send(8'h00, 0, 1'b0, '0);
    send(8'b0000_1001, 4, 1'b0, '0);
    idle_cycles(2);

    // Async reset mid-pattern (bit 3 of 0xFF): checked directly, scoreboard paused.
    @(negedge clk);
    mon_en = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.din   = 8'hFF;
    bus.nbits = LW'(8);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("before_rst", sample(), '{x: 1'b1, busy: 1'b1, done: 1'b0, ready: 1'b0});
    #1 rst = 1'b1;
    #1;
    check("async_rst", sample(), IDLE_OBS);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    send(8'h96, 8, 1'b0, '0);
    idle_cycles(1);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      send(WIDTH'($urandom), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
           WIDTH'($urandom));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    idle_cycles(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending records, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
